// File: rtl/qsysdemo_cpu_debug_scan_master_if.sv
// Command/response handshake and virtual-JTAG signal bundle for the debug scan master.
// The master modport is the scan engine; the slave modport is the host plus the debug slave.
interface qsysdemo_cpu_debug_scan_master_if #(
  parameter int SR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;
  logic [1:0]          rsp_ir;
  logic                tck;
  logic                tdi;
  logic [1:0]          ir_in;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_udr;
  logic                jtag_state_rti;
  logic                tdo;
  logic [1:0]          ir_out;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo, ir_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir,
    output tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo, ir_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir,
    input  tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/qsysdemo_cpu_debug_scan_master.sv
// Virtual-JTAG DR scan engine: one command = UIR, CDR, SDR x SR_WIDTH, UDR, [RTI], response.
// Define QSYSDEMO_DEBUG_SCAN_MASTER_RTI_EN to add the run-test-idle phase after UDR.
module qsysdemo_cpu_debug_scan_master #(
  parameter int SR_WIDTH   = 38,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  qsysdemo_cpu_debug_scan_master_if.master bus
);

  localparam int DIV_W = 9;
  localparam int CNT_W = $clog2(SR_WIDTH + 256);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_HALF);
  localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(SR_WIDTH - 1);
`ifdef QSYSDEMO_DEBUG_SCAN_MASTER_RTI_EN
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, UIR, CDR, SDR, UDR, RTI, RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIV_W-1:0]    r_div;
  logic [CNT_W-1:0]    r_cnt;
  logic [SR_WIDTH-1:0] r_sr;
  logic                r_tdi;
  logic [1:0]          r_ir_in;
  logic [1:0]          r_rsp_ir;
  logic                w_busy;
  logic                w_end;
  logic                w_rise;
  logic                w_accept;

  // r_div walks one tck period; w_rise is the last low-phase clk, w_end the last high-phase clk
  assign w_busy   = (r_state != IDLE) && (r_state != RESP);
  assign w_end    = w_busy && (r_div == DIV_LAST);
  assign w_rise   = w_busy && (r_div == DIV_RISE);
  assign w_accept = (r_state == IDLE) && bus.cmd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.cmd_valid) w_next = UIR;
      UIR:  if (w_end) w_next = CDR;
      CDR:  if (w_end) w_next = SDR;
      SDR:  if (w_end && (r_cnt == SDR_LAST)) w_next = UDR;
`ifdef QSYSDEMO_DEBUG_SCAN_MASTER_RTI_EN
      UDR:  if (w_end) w_next = RTI;
      RTI:  if (w_end && (r_cnt == RTI_LAST)) w_next = RESP;
`else
      UDR:  if (w_end) w_next = RESP;
      RTI:  w_next = RESP;
`endif
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_cnt    <= '0;
      r_sr     <= '0;
      r_tdi    <= 1'b0;
      r_ir_in  <= 2'b00;
      r_rsp_ir <= 2'b00;
    end else begin
      if (w_busy && !w_end) r_div <= r_div + DIV_W'(1);
      else                  r_div <= '0;

      if (r_state != w_next) r_cnt <= '0;
      else if (w_end)        r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        r_sr    <= bus.cmd_data;
        r_ir_in <= bus.cmd_ir;
      end else if (w_rise && (r_state == SDR)) begin
        r_sr <= {bus.tdo, r_sr[SR_WIDTH-1:1]};
      end

      if (w_rise && (r_state == CDR)) r_rsp_ir <= bus.ir_out;

      // tdi is re-registered at each period boundary so it only moves as a low phase begins;
      // by then the rising-edge shift has already exposed the next bit in r_sr[0]
      if (w_end) r_tdi <= (w_next == SDR) ? r_sr[0] : 1'b0;
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_data  = r_sr;
  assign bus.rsp_ir    = r_rsp_ir;
  assign bus.tck       = w_busy && (r_div >= DIV_HIGH);
  assign bus.tdi       = r_tdi;
  assign bus.ir_in     = r_ir_in;
  assign bus.vs_uir    = (r_state == UIR);
  assign bus.vs_cdr    = (r_state == CDR);
  assign bus.vs_sdr    = (r_state == SDR);
  assign bus.vs_udr    = (r_state == UDR);
`ifdef QSYSDEMO_DEBUG_SCAN_MASTER_RTI_EN
  assign bus.jtag_state_rti = (r_state == RTI);
`else
  assign bus.jtag_state_rti = 1'b0;
`endif

endmodule
